// File: rtl/reg_file_param.sv
// reg_file_param: multi-ported register file with two write ports, two
// registered read ports (write-first bypass), synchronous clear, per-register
// dirty flags and an optional hard-wired zero register.
module reg_file_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    WRITE0,
   input  logic [AW-1:0]           IN0ADDRESS,
   input  logic signed [WIDTH-1:0] IN0,
   input  logic                    WRITE1,
   input  logic [AW-1:0]           IN1ADDRESS,
   input  logic signed [WIDTH-1:0] IN1,
   input  logic                    CLEAR,
   input  logic [AW-1:0]           OUT1ADDRESS,
   input  logic [AW-1:0]           OUT2ADDRESS,
   output logic signed [WIDTH-1:0] OUT1,
   output logic signed [WIDTH-1:0] OUT2,
   output logic [DEPTH-1:0]        DIRTY
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] dirty_q, dirty_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic [WIDTH-1:0] out2_q, out2_d;
   logic             wr0_ok, wr1_ok;

   // A write is effective only when enabled and not aimed at a hard-wired zero register.
   always_comb begin
      wr0_ok = WRITE0 && !((ZERO_REG != 0) && (IN0ADDRESS == '0));
      wr1_ok = WRITE1 && !((ZERO_REG != 0) && (IN1ADDRESS == '0));
   end

   // Next register/dirty state: clear wins, otherwise port 0 then port 1 so port 1 wins on collisions.
   always_comb begin
      regs_d  = regs_q;
      dirty_d = dirty_q;
      if (CLEAR) begin
         for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
         dirty_d = '0;
      end else begin
         if (wr0_ok) begin
            regs_d[IN0ADDRESS]  = IN0;
            dirty_d[IN0ADDRESS] = 1'b1;
         end
         if (wr1_ok) begin
            regs_d[IN1ADDRESS]  = IN1;
            dirty_d[IN1ADDRESS] = 1'b1;
         end
      end
   end

   // Read port 1: clear forces zero, else write-first bypass with port 1 priority, else stored value.
   always_comb begin
      out1_d = regs_q[OUT1ADDRESS];
      if (CLEAR || ((ZERO_REG != 0) && (OUT1ADDRESS == '0))) out1_d = '0;
      else if (wr1_ok && (IN1ADDRESS == OUT1ADDRESS))       out1_d = IN1;
      else if (wr0_ok && (IN0ADDRESS == OUT1ADDRESS))       out1_d = IN0;
   end

   // Read port 2: same selection rules as read port 1.
   always_comb begin
      out2_d = regs_q[OUT2ADDRESS];
      if (CLEAR || ((ZERO_REG != 0) && (OUT2ADDRESS == '0))) out2_d = '0;
      else if (wr1_ok && (IN1ADDRESS == OUT2ADDRESS))       out2_d = IN1;
      else if (wr0_ok && (IN0ADDRESS == OUT2ADDRESS))       out2_d = IN0;
   end

   // State registers; reset clears everything immediately regardless of the clock.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         dirty_q <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         dirty_q <= dirty_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
      end
   end

   // Drive outputs straight from the registers.
   always_comb begin
      OUT1  = out1_q;
      OUT2  = out2_q;
      DIRTY = dirty_q;
   end

endmodule
